// File: rtl/wr_port_arbiter.sv
// wr_port_arbiter
//
// Round-robin arbiter that shares the async FIFO write port (winc/wdata,
// gated by wfull) among NREQ valid/ready requesters. One requester holds
// the grant at a time, for up to BURST beats. When a grant is released,
// the arbiter rescans in the same cycle, so throughput stays at one beat
// per cycle across grant boundaries.
//
// Optional feature:
//   ARB_PKT_LOCK_EN - the grant is held until a beat with req_last is
//                     accepted. BURST is ignored and a valid gap does not
//                     release the grant. When undefined, req_last is ignored.
//
// Ports:
//   wclk       in   write-domain clock
//   wrst_n     in   asynchronous active-low reset
//   req_valid  in   [NREQ]        per-requester beat valid
//   req_data   in   [NREQ*DSIZE]  requester i at [i*DSIZE +: DSIZE]
//   req_last   in   [NREQ]        end-of-packet marker (packet lock only)
//   req_ready  out  [NREQ]        per-requester beat accept
//   wfull      in   registered FIFO full flag
//   winc       out  FIFO write strobe
//   wdata      out  [DSIZE]       FIFO write data
//   gnt_valid  out  a requester holds the grant
//   gnt_id     out  [clog2(NREQ)] index of the granted requester
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no grant; scan from rr_ptr whenever any requester is valid
// GRANT | gnt_id owns the write port; beats forwarded while !wfull

module wr_port_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int DSIZE = 8,
    parameter  int BURST = 4,
    localparam int IDW   = $clog2(NREQ),
    localparam int CW    = $clog2(BURST + 1)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic                  gnt_valid,
    output logic [IDW-1:0]        gnt_id
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  gnt_q, gnt_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [DSIZE-1:0] lane [NREQ];
    logic [IDW-1:0]   gnt_nxt;
    logic [IDW:0]     pick_idle;
    logic [IDW:0]     pick_rel;
    logic             xfer;
    logic             rel;

    // First valid requester at or after 'start' (mod NREQ); MSB flags a hit.
    // Scanning downward lets the nearest hit overwrite farther ones.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  start);
        logic [IDW:0] pick;
        logic [IDW:0] idx;
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, start} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (v[idx[IDW-1:0]]) begin
                pick = {1'b1, idx[IDW-1:0]};
            end
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            lane[i] = req_data[i*DSIZE +: DSIZE];
        end
    end

    always_comb begin
        if (gnt_q == IDW'(NREQ - 1)) begin
            gnt_nxt = '0;
        end else begin
            gnt_nxt = gnt_q + IDW'(1);
        end
    end

    // The rescan on release starts after the current owner, so the owner
    // comes last and only regains the port if nobody else is waiting.
    assign pick_idle = rr_pick(req_valid, rr_q);
    assign pick_rel  = rr_pick(req_valid, gnt_nxt);

`ifndef ARB_PKT_LOCK_EN
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        winc      = 1'b0;
        wdata     = lane[gnt_q];
        xfer      = 1'b0;
        rel       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_idle[IDW]) begin
                    state_d = GRANT;
                    gnt_d   = pick_idle[IDW-1:0];
                    cnt_d   = '0;
                end
            end

            GRANT: begin
                req_ready[gnt_q] = ~wfull;
                winc             = req_valid[gnt_q] & ~wfull;
                xfer             = winc;
`ifdef ARB_PKT_LOCK_EN
                rel = xfer & req_last[gnt_q];
                if (xfer && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CW'(1);
                end
`else
                // wfull alone never releases: it only stops xfer.
                rel = (xfer && (cnt_q == CW'(BURST - 1))) || !req_valid[gnt_q];
                if (xfer) begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
                if (rel) begin
                    rr_d  = gnt_nxt;
                    cnt_d = '0;
                    if (pick_rel[IDW]) begin
                        gnt_d = pick_rel[IDW-1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt_id    = gnt_q;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// tb_wr_port_arbiter
//
// Self-checking bench for wr_port_arbiter (NREQ=4, DSIZE=8, BURST=4).
// Inputs are driven on the falling edge, and outputs are sampled 1 ns
// later, so no sample falls on a rising edge. The directed tasks cover the
// burst, round-robin, wfull, valid-drop and reset cases. A random phase
// compares every cycle with a grant-ownership model. The model tracks the
// owner, the beats delivered and the next starting index.

module tb_wr_port_arbiter;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;

    logic                  wclk = 1'b0;
    logic                  wrst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*DSIZE-1:0] req_data = '0;
    logic [NREQ-1:0]       req_last = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull = 1'b0;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic                  gnt_valid;
    logic [1:0]            gnt_id;

    int checks = 0;
    int errors = 0;

    wr_port_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 wclk = ~wclk;

    function automatic logic [DSIZE-1:0] lane_of(input int i);
        return req_data[i*DSIZE +: DSIZE];
    endfunction

    function automatic int first_from(input logic [NREQ-1:0] v, input int s);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(s + k) % NREQ]) return (s + k) % NREQ;
        end
        return -1;
    endfunction

    // Returns on a falling edge with reset released, so the caller can
    // drive "cycle 0" immediately.
    task automatic apply_reset();
        wrst_n    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        wfull     = 1'b0;
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        wrst_n    = 1'b0;
        req_valid = '1;
        req_data  = $urandom();
        repeat (2) @(negedge wclk);
        #1;
        checks++;
        if (gnt_valid !== 1'b0 || winc !== 1'b0 || req_ready !== 4'b0000 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt_valid=%b winc=%b ready=%b gnt_id=%0d, expected 0/0/0000/0",
                     gnt_valid, winc, req_ready, gnt_id);
        end
        checks++;
        if (wdata !== lane_of(0)) begin
            errors++;
            $display("FAIL reset_wdata: got %h expected %h", wdata, lane_of(0));
        end
    endtask

    task automatic test_single();
        apply_reset();
        req_valid = 4'b0100;
        req_data  = $urandom();
        #1;
        checks++;
        if (gnt_valid !== 1'b0 || winc !== 1'b0) begin
            errors++;
            $display("FAIL single_latency0: got gnt_valid=%b winc=%b expected 0/0", gnt_valid, winc);
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge wclk);
            req_data = $urandom();
            #1;
            checks++;
            if (gnt_valid !== 1'b1 || gnt_id !== 2'd2 || winc !== 1'b1 ||
                req_ready !== 4'b0100 || wdata !== lane_of(2)) begin
                errors++;
                $display("FAIL single_beat k=%0d: got gv=%b id=%0d winc=%b rdy=%b wdata=%h expected 1/2/1/0100/%h",
                         k, gnt_valid, gnt_id, winc, req_ready, wdata, lane_of(2));
            end
        end
        @(negedge wclk);
        req_valid = 4'b1001;
        #1;
        checks++;
        if (winc !== 1'b0 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL single_drop: got winc=%b id=%0d expected 0/2", winc, gnt_id);
        end
        @(negedge wclk);
        #1;
        checks++;
        if (gnt_id !== 2'd3 || winc !== 1'b1 || req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL single_regrant: got id=%0d winc=%b rdy=%b expected 3/1/1000", gnt_id, winc, req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_all_valid();
        int exp_id;
        apply_reset();
        req_valid = '1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge wclk);
            req_data = $urandom();
            #1;
            exp_id = ((k - 1) / BURST) % NREQ;
            checks++;
            if (gnt_id !== 2'(exp_id) || winc !== 1'b1 || wdata !== lane_of(exp_id)) begin
                errors++;
                $display("FAIL all_valid k=%0d: got id=%0d winc=%b wdata=%h expected %0d/1/%h",
                         k, gnt_id, winc, wdata, exp_id, lane_of(exp_id));
            end
        end
        req_valid = '0;
    endtask

    task automatic test_wfull();
        logic [3:0] exp_rdy;
        apply_reset();
        req_valid = 4'b0010;
        for (int k = 1; k <= 10; k++) begin
            @(negedge wclk);
            wfull = (k >= 3 && k <= 7);
            if (k == 9) req_valid = 4'b0011;
            req_data = $urandom();
            #1;
            if (k <= 9) begin
                exp_rdy = wfull ? 4'b0000 : 4'b0010;
                checks++;
                if (gnt_valid !== 1'b1 || gnt_id !== 2'd1 || winc !== !wfull ||
                    req_ready !== exp_rdy || (!wfull && wdata !== lane_of(1))) begin
                    errors++;
                    $display("FAIL wfull_hold k=%0d: got gv=%b id=%0d winc=%b rdy=%b expected 1/1/%b/%b",
                             k, gnt_valid, gnt_id, winc, req_ready, !wfull, exp_rdy);
                end
            end else begin
                checks++;
                if (gnt_id !== 2'd0 || winc !== 1'b1) begin
                    errors++;
                    $display("FAIL wfull_release: got id=%0d winc=%b expected 0/1", gnt_id, winc);
                end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_valid_drop();
        apply_reset();
        req_valid = 4'b1001;
        @(negedge wclk);
        #1;
        checks++;
        if (gnt_id !== 2'd0 || winc !== 1'b1) begin
            errors++;
            $display("FAIL drop_first: got id=%0d winc=%b expected 0/1", gnt_id, winc);
        end
        @(negedge wclk);
        req_valid = 4'b1000;
        #1;
        checks++;
        if (gnt_id !== 2'd0 || winc !== 1'b0 || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL drop_gap: got id=%0d winc=%b rdy=%b expected 0/0/0001", gnt_id, winc, req_ready);
        end
        @(negedge wclk);
        #1;
        checks++;
        if (gnt_valid !== 1'b1 || gnt_id !== 2'd3 || winc !== 1'b1 || req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL drop_regrant: got gv=%b id=%0d winc=%b rdy=%b expected 1/3/1/1000",
                     gnt_valid, gnt_id, winc, req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_valid = '1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge wclk);
            #1;
            checks++;
            if (gnt_id !== 2'((k - 1) / BURST) || winc !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_pre k=%0d: got id=%0d winc=%b expected %0d/1", k, gnt_id, winc, (k - 1) / BURST);
            end
        end
        wrst_n = 1'b0;
        #1;
        checks++;
        if (winc !== 1'b0 || gnt_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_async: got winc=%b gv=%b rdy=%b expected 0/0/0000", winc, gnt_valid, req_ready);
        end
        @(negedge wclk);
        wrst_n = 1'b1;
        @(negedge wclk);
        #1;
        checks++;
        if (gnt_valid !== 1'b1 || gnt_id !== 2'd0 || winc !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_restart: got gv=%b id=%0d winc=%b expected 1/0/1", gnt_valid, gnt_id, winc);
        end
        req_valid = '0;
    endtask

`ifdef ARB_PKT_LOCK_EN
    task automatic test_pkt_lock();
        logic [3:0] vtab [9];
        vtab = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0010, 4'b0010, 4'b1010};
        apply_reset();
        req_valid = vtab[0];
        for (int k = 1; k <= 9; k++) begin
            @(negedge wclk);
            if (k <= 8) req_valid = vtab[k];
            req_last = (k == 8) ? 4'b0010 : 4'b0000;
            req_data = $urandom();
            #1;
            if (k <= 8) begin
                checks++;
                if (gnt_id !== 2'd1 || gnt_valid !== 1'b1 || winc !== (k != 4 && k != 5) ||
                    req_ready !== 4'b0010) begin
                    errors++;
                    $display("FAIL pkt_hold k=%0d: got id=%0d gv=%b winc=%b rdy=%b expected 1/1/%b/0010",
                             k, gnt_id, gnt_valid, winc, req_ready, (k != 4 && k != 5));
                end
            end else begin
                checks++;
                if (gnt_id !== 2'd3 || winc !== 1'b1) begin
                    errors++;
                    $display("FAIL pkt_release: got id=%0d winc=%b expected 3/1", gnt_id, winc);
                end
            end
        end
        req_valid = '0;
        req_last  = '0;
    endtask
`endif

    task automatic test_random();
        bit         m_busy;
        int         m_own;
        int         m_done;
        int         m_ptr;
        int         nxt;
        bit         exp_winc;
        bit         fire;
        bit         rel;
        logic [3:0] exp_rdy;
        apply_reset();
        m_busy = 0;
        m_own  = 0;
        m_done = 0;
        m_ptr  = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n > 0) @(negedge wclk);
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                req_last[i]  = ($urandom_range(0, 2) == 0);
            end
            wfull    = ($urandom_range(0, 3) == 0);
            req_data = $urandom();
            #1;
            exp_winc = m_busy && req_valid[m_own] && !wfull;
            exp_rdy  = (m_busy && !wfull) ? (4'b0001 << m_own) : 4'b0000;
            checks++;
            if (gnt_valid !== m_busy || winc !== exp_winc || req_ready !== exp_rdy ||
                (m_busy && gnt_id !== 2'(m_own)) || (exp_winc && wdata !== lane_of(m_own))) begin
                errors++;
                $display("FAIL random n=%0d: got gv=%b id=%0d winc=%b rdy=%b wdata=%h expected %b/%0d/%b/%b/%h",
                         n, gnt_valid, gnt_id, winc, req_ready, wdata,
                         m_busy, m_own, exp_winc, exp_rdy, lane_of(m_own));
            end
            if (!m_busy) begin
                nxt = first_from(req_valid, m_ptr);
                if (nxt >= 0) begin
                    m_busy = 1;
                    m_own  = nxt;
                    m_done = 0;
                end
            end else begin
                fire = exp_winc;
                if (fire) m_done++;
`ifdef ARB_PKT_LOCK_EN
                rel = fire && req_last[m_own];
`else
                rel = (fire && m_done == BURST) || !req_valid[m_own];
`endif
                if (rel) begin
                    m_ptr = (m_own + 1) % NREQ;
                    nxt   = first_from(req_valid, m_ptr);
                    m_done = 0;
                    if (nxt >= 0) m_own = nxt;
                    else m_busy = 0;
                end
            end
        end
        req_valid = '0;
        wfull     = 1'b0;
    endtask

    initial begin
        test_reset();
`ifndef ARB_PKT_LOCK_EN
        test_single();
        test_all_valid();
        test_wfull();
        test_valid_drop();
        test_reset_mid();
`else
        test_pkt_lock();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
